// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  // Converter control states: wait for a word, shift it through, hold result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digits at or above this threshold get corrected before each shift.
  localparam logic [3:0] BCD_ADD3_TH = 4'd5;
  localparam logic [3:0] BCD_ADD3    = 4'd3;
  // Saturation digit used when the value does not fit the digit count.
  localparam logic [3:0] BCD_NINE    = 4'h9;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit shift-add-3 corrector: a digit of 5..9 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
// Purely combinational, 4-bit wrap, no carry out to the neighbouring digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_ADD3_TH) ? (d + BCD_ADD3) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; a producer holds valid (and its data) until it sees ready.
// Results that need more than DIGITS digits saturate to all 9s with ovf=1.
// Optional macro BCD_BLANK_EN adds the leading-zero blank output.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]     blank,
`endif
  output state_t                dbg_state
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    bin_q;
  logic [BCD_W-1:0]   dig_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_acc_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   dig_adj;
  logic [BCD_W-1:0]   dig_shift;
  logic [IN_W-1:0]    bin_shift;
  logic               ovf_next;
  logic               last_shift;
  logic [BCD_W-1:0]   bcd_final;

  // Per-digit +3 correction ahead of the shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .d (dig_q[4*k +: 4]),
      .q (dig_adj[4*k +: 4])
    );
  end

  // A 1 leaving the top digit means the value no longer fits; it is sticky.
  assign dig_shift  = {dig_adj[BCD_W-2:0], bin_q[IN_W-1]};
  assign bin_shift  = bin_q << 1;
  assign ovf_next   = ovf_acc_q | dig_adj[BCD_W-1];
  assign last_shift = (cnt_q == CNT_W'(IN_W - 1));
  assign bcd_final  = ovf_next ? {DIGITS{BCD_NINE}} : dig_shift;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: accept, shift IN_W times, hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, shift during SHIFT, capture result on last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q     <= value;
            dig_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
          end
        end
        SHIFT: begin
          bin_q     <= bin_shift;
          dig_q     <= dig_shift;
          cnt_q     <= cnt_q + CNT_W'(1);
          ovf_acc_q <= ovf_next;
          if (last_shift) begin
            bcd_q <= bcd_final;
            ovf_q <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              zero_above;

  // Leading-zero mask: a digit blanks when it and every digit above are 0.
  // The ones digit never blanks, and a saturated result shows all digits.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (bcd_final[4*k +: 4] == 4'd0);
      blank_d[k] = zero_above & ~ovf_next;
    end
  end

  // Blank mask is registered alongside bcd so they change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          blank_q <= '0;
    else if (state_q == SHIFT && last_shift) blank_q <= blank_d;
  end

  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three instances (8b/3 digits, 8b/2 digits,
// 16b/5 digits) driven by shared tasks; directed table, handshake and reset
// sequences, plus a random sweep against a decimal reference model.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  logic clk;
  logic rst_n;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: IN_W=8, DIGITS=3
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [7:0]  a_value;
  logic [11:0] a_bcd;
  state_t      a_dbg_state;
  // Instance B: IN_W=8, DIGITS=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [7:0]  b_value;
  logic [7:0]  b_bcd;
  state_t      b_dbg_state;
  // Instance C: IN_W=16, DIGITS=5
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
  logic [15:0] c_value;
  logic [19:0] c_bcd;
  state_t      c_dbg_state;
`ifdef BCD_BLANK_EN
  logic [2:0]  a_blank;
  logic [1:0]  b_blank;
  logic [4:0]  c_blank;
`endif

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .value(a_value), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd(a_bcd), .ovf(a_ovf),
`ifdef BCD_BLANK_EN
    .blank(a_blank),
`endif
    .dbg_state(a_dbg_state));

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .value(b_value), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd(b_bcd), .ovf(b_ovf),
`ifdef BCD_BLANK_EN
    .blank(b_blank),
`endif
    .dbg_state(b_dbg_state));

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .value(c_value), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .bcd(c_bcd), .ovf(c_ovf),
`ifdef BCD_BLANK_EN
    .blank(c_blank),
`endif
    .dbg_state(c_dbg_state));

  int n_checks = 0;
  int n_err    = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decimal digits by division, saturating to 9s.
  function automatic logic [19:0] ref_bcd(input int unsigned v, input int digits);
    int unsigned lim = 1;
    logic [19:0] r = '0;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    for (int k = 0; k < digits; k++) begin
      if (v >= lim) r[4*k +: 4] = 4'h9;
      else begin
        r[4*k +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic int in_w_of(input int sel);
    return (sel == 2) ? 16 : 8;
  endfunction

  // Driver tasks
  task automatic set_in(input int sel, input logic iv, input logic [15:0] v);
    case (sel)
      0: begin a_in_valid = iv; a_value = v[7:0]; end
      1: begin b_in_valid = iv; b_value = v[7:0]; end
      default: begin c_in_valid = iv; c_value = v; end
    endcase
  endtask

  task automatic set_ordy(input int sel, input logic r);
    case (sel)
      0: a_out_ready = r;
      1: b_out_ready = r;
      default: c_out_ready = r;
    endcase
  endtask

  task automatic get_out(input int sel, output logic ov, output logic ir,
                         output logic [19:0] bc, output logic of, output logic [4:0] bl);
    bl = '0;
    case (sel)
      0: begin ov = a_out_valid; ir = a_in_ready; bc = 20'(a_bcd); of = a_ovf;
`ifdef BCD_BLANK_EN
         bl = 5'(a_blank);
`endif
      end
      1: begin ov = b_out_valid; ir = b_in_ready; bc = 20'(b_bcd); of = b_ovf;
`ifdef BCD_BLANK_EN
         bl = 5'(b_blank);
`endif
      end
      default: begin ov = c_out_valid; ir = c_in_ready; bc = c_bcd; of = c_ovf;
`ifdef BCD_BLANK_EN
         bl = c_blank;
`endif
      end
    endcase
  endtask

  // One conversion: present value, accept, scramble input, count clocks to
  // out_valid, capture outputs, consume with a one-cycle out_ready pulse.
  task automatic conv(input int sel, input logic [15:0] v, output logic [19:0] r_bcd,
                      output logic r_ovf, output logic [4:0] r_blank, output int lat);
    logic ov, ir;
    @(negedge clk);
    set_in(sel, 1'b1, v);
    @(posedge clk);
    #1 set_in(sel, 1'b0, ~v);
    lat = 0;
    get_out(sel, ov, ir, r_bcd, r_ovf, r_blank);
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      get_out(sel, ov, ir, r_bcd, r_ovf, r_blank);
    end
    @(negedge clk) set_ordy(sel, 1'b1);
    @(posedge clk);
    #1 set_ordy(sel, 1'b0);
  endtask

  typedef struct {
    int          sel;
    logic [15:0] value;
    logic [19:0] exp_bcd;
    logic        exp_ovf;
    logic [4:0]  exp_blank;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [19:0] r_bcd, e_bcd;
    logic        r_ovf, ov, ir;
    logic [4:0]  r_blank;
    int          lat;

    // Watchdog so the bench always ends.
    fork
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    vecs[0]  = '{0, 16'd255,   20'h00255, 1'b0, 5'b00000};
    vecs[1]  = '{0, 16'd0,     20'h00000, 1'b0, 5'b00110};
    vecs[2]  = '{0, 16'd7,     20'h00007, 1'b0, 5'b00110};
    vecs[3]  = '{0, 16'd40,    20'h00040, 1'b0, 5'b00100};
    vecs[4]  = '{0, 16'd100,   20'h00100, 1'b0, 5'b00000};
    vecs[5]  = '{0, 16'd9,     20'h00009, 1'b0, 5'b00110};
    vecs[6]  = '{0, 16'd10,    20'h00010, 1'b0, 5'b00100};
    vecs[7]  = '{1, 16'd100,   20'h00099, 1'b1, 5'b00000};
    vecs[8]  = '{1, 16'd99,    20'h00099, 1'b0, 5'b00000};
    vecs[9]  = '{1, 16'd255,   20'h00099, 1'b1, 5'b00000};
    vecs[10] = '{1, 16'd5,     20'h00005, 1'b0, 5'b00010};
    vecs[11] = '{1, 16'd10,    20'h00010, 1'b0, 5'b00000};
    vecs[12] = '{2, 16'd65535, 20'h65535, 1'b0, 5'b00000};
    vecs[13] = '{2, 16'd0,     20'h00000, 1'b0, 5'b11110};
    vecs[14] = '{2, 16'd1000,  20'h01000, 1'b0, 5'b10000};

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_in(s, 1'b0, 16'd0);
      set_ordy(s, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(a_in_ready), 32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_bcd",       32'(a_bcd), 32'd0);
    check("rst_ovf",       32'(a_ovf), 32'd0);
    check("rst_state",     32'(a_dbg_state), 32'(IDLE));
`ifdef BCD_BLANK_EN
    check("rst_blank",     32'(a_blank), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      conv(vecs[i].sel, vecs[i].value, r_bcd, r_ovf, r_blank, lat);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(in_w_of(vecs[i].sel)));
      check($sformatf("tbl%0d_bcd", i), 32'(r_bcd), 32'(vecs[i].exp_bcd));
      check($sformatf("tbl%0d_ovf", i), 32'(r_ovf), 32'(vecs[i].exp_ovf));
`ifdef BCD_BLANK_EN
      check($sformatf("tbl%0d_blank", i), 32'(r_blank), 32'(vecs[i].exp_blank));
`endif
    end

    // Backpressure: result held while out_ready stays low
    @(negedge clk) set_in(0, 1'b1, 16'd37);
    @(posedge clk);
    #1 set_in(0, 1'b0, 16'd0);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_valid", i), 32'(a_out_valid), 32'd1);
      check($sformatf("bp%0d_bcd", i), 32'(a_bcd), 32'h037);
      check($sformatf("bp%0d_in_ready", i), 32'(a_in_ready), 32'd0);
    end
    @(negedge clk) a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b0;
    check("bp_release_in_ready",  32'(a_in_ready), 32'd1);
    check("bp_release_out_valid", 32'(a_out_valid), 32'd0);

    // Reset during SHIFT with cnt=3 clears outputs at once
    @(negedge clk) set_in(0, 1'b1, 16'd200);
    @(posedge clk);
    #1 set_in(0, 1'b0, 16'd0);
    repeat (3) @(posedge clk);
    #2;
    check("mid_state_shift", 32'(a_dbg_state), 32'(SHIFT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd",       32'(a_bcd), 32'd0);
    check("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_ovf",       32'(a_ovf), 32'd0);
    check("mid_rst_state",     32'(a_dbg_state), 32'(IDLE));
    @(negedge clk) rst_n = 1'b1;
    conv(0, 16'd42, r_bcd, r_ovf, r_blank, lat);
    check("post_rst_latency", 32'(lat), 32'd8);
    check("post_rst_bcd",     32'(r_bcd), 32'h042);
    check("post_rst_ovf",     32'(r_ovf), 32'd0);

    // Random sweep through the scoreboard queue
    for (int i = 0; i < 24; i++) begin
      int sel;
      int unsigned v;
      sel = (i < 8) ? 0 : ((i < 12) ? 1 : 2);
      v   = (sel == 2) ? $urandom_range(0, 65535) : $urandom_range(0, 255);
      exp_q.push_back(ref_bcd(v, (sel == 0) ? 3 : ((sel == 1) ? 2 : 5)));
      conv(sel, 16'(v), r_bcd, r_ovf, r_blank, lat);
      e_bcd = exp_q.pop_front();
      check($sformatf("rnd%0d_bcd v=%0d", i, v), 32'(r_bcd), 32'(e_bcd));
      check($sformatf("rnd%0d_ovf v=%0d", i, v), 32'(r_ovf),
            32'((sel == 1) && (v > 99)));
    end

    get_out(2, ov, ir, r_bcd, r_ovf, r_blank);
    check("end_c_in_ready", 32'(ir), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
